controle_vedacao: RTL and testbench

Sealing-station controller that consumes corks from the cork counter. When a bottle is in the sealing position it requests exactly one cork (one-cycle `dec` pulse to the cork counter), drives the sealing actuator for a fixed time, releases the bottle to the conveyor and counts sealed bottles. It stalls the conveyor and raises an alarm when no cork is available. It never requests a cork while the counter is refilling.

---
 rtl/vedacao_pkg.sv | 29 ++
 rtl/temporizador_vedacao.sv | 32 +++
 rtl/controle_vedacao.sv | 104 ++++++++++
 tb/tb_controle_vedacao.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vedacao_pkg.sv
// Shared definitions for the sealing-station controller: state encoding,
// parameter defaults and the conveyor-enable decode.
package vedacao_pkg;

   localparam logic [2:0] EST_OCIOSO        = 3'd0;
   localparam logic [2:0] EST_REQUISITA     = 3'd1;
   localparam logic [2:0] EST_VEDANDO       = 3'd2;
   localparam logic [2:0] EST_LIBERA        = 3'd3;
   localparam logic [2:0] EST_AGUARDA_SAIDA = 3'd4;
   localparam logic [2:0] EST_SEM_ROLHA     = 3'd5;

   typedef enum logic [2:0] {
      OCIOSO        = EST_OCIOSO,
      REQUISITA     = EST_REQUISITA,
      VEDANDO       = EST_VEDANDO,
      LIBERA        = EST_LIBERA,
      AGUARDA_SAIDA = EST_AGUARDA_SAIDA,
      SEM_ROLHA     = EST_SEM_ROLHA
   } estado_t;

   localparam int TEMPO_VEDACAO_PADRAO   = 4;
   localparam int LARGURA_VEDADAS_PADRAO = 8;

   // The conveyor only runs while no bottle is being held for sealing.
   function automatic logic esteira_livre(input estado_t e);
      return (e == OCIOSO) || (e == LIBERA) || (e == AGUARDA_SAIDA);
   endfunction

endpackage

// File: rtl/temporizador_vedacao.sv
// Sealing-time down-counter: loads TEMPO_VEDACAO-1 and counts down to zero,
// flagging fim while the count is zero.
module temporizador_vedacao
   import vedacao_pkg::*;
#(
   parameter int TEMPO_VEDACAO = TEMPO_VEDACAO_PADRAO
) (
   input  logic clk,
   input  logic reset,
   input  logic carga,
   input  logic conta,
   output logic fim
);

   localparam int LARGURA = $clog2(TEMPO_VEDACAO + 1);
   localparam logic [LARGURA-1:0] VALOR_CARGA = LARGURA'(TEMPO_VEDACAO - 1);

   logic [LARGURA-1:0] contagem;

   always_ff @(posedge clk) begin
      if (!reset) begin
         contagem <= '0;
      end else if (carga) begin
         contagem <= VALOR_CARGA;
      end else if (conta && (contagem != '0)) begin
         contagem <= contagem - 1'b1;
      end
   end

   assign fim = (contagem == '0);

endmodule

// File: rtl/controle_vedacao.sv
// Sealing-station controller: takes one cork per bottle from the cork counter,
// drives the sealing actuator for a fixed time and counts sealed bottles.
//
// state         | meaning
// --------------+--------------------------------------------------------
// OCIOSO        | conveyor running, waiting for a bottle (and key in manual)
// REQUISITA     | conveyor stopped, requesting one cork (dec when pode)
// VEDANDO       | actuator driven for TEMPO_VEDACAO cycles
// LIBERA        | one-cycle release pulse, sealed count incremented
// AGUARDA_SAIDA | conveyor running, waiting for the sealed bottle to leave
// SEM_ROLHA     | conveyor stopped, alarm raised, no cork available
module controle_vedacao
   import vedacao_pkg::*;
#(
   parameter int TEMPO_VEDACAO   = TEMPO_VEDACAO_PADRAO,
   parameter int LARGURA_VEDADAS = LARGURA_VEDADAS_PADRAO
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       garrafa_presente,
   input  logic                       modo_manual,
   input  logic                       key_vedar,
   input  logic                       rolha_disponivel,
   input  logic                       disp_acionado,
   output logic                       dec,
   output logic                       atuador_vedar,
   output logic                       garrafa_liberada,
   output logic                       esteira_habilitada,
   output logic                       alarme_sem_rolha,
   output logic [LARGURA_VEDADAS-1:0] vedadas
);

   estado_t estado;
   estado_t proximo;
   logic    pode;
   logic    inicio;
   logic    fim_tempo;

   // A dec during refill would be dropped by the cork counter, so wait it out.
   assign pode   = rolha_disponivel && !disp_acionado;
   assign inicio = garrafa_presente && (!modo_manual || key_vedar);
   assign dec    = (estado == REQUISITA) && pode;

   temporizador_vedacao #(
      .TEMPO_VEDACAO (TEMPO_VEDACAO)
   ) u_temporizador (
      .clk   (clk),
      .reset (reset),
      .carga (dec),
      .conta (estado == VEDANDO),
      .fim   (fim_tempo)
   );

   always_comb begin
      proximo = estado;
      case (estado)
         OCIOSO: begin
            if (inicio) proximo = REQUISITA;
         end
         REQUISITA: begin
            if (pode)                                   proximo = VEDANDO;
            else if (!rolha_disponivel && !disp_acionado) proximo = SEM_ROLHA;
         end
         VEDANDO: begin
            if (fim_tempo) proximo = LIBERA;
         end
         LIBERA: begin
            proximo = AGUARDA_SAIDA;
         end
         AGUARDA_SAIDA: begin
            if (!garrafa_presente) proximo = OCIOSO;
         end
         SEM_ROLHA: begin
            if (pode)                   proximo = REQUISITA;
            else if (!garrafa_presente) proximo = OCIOSO;
         end
         default: begin
            proximo = OCIOSO;
         end
      endcase
   end

   // Moore outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         estado             <= OCIOSO;
         atuador_vedar      <= 1'b0;
         garrafa_liberada   <= 1'b0;
         esteira_habilitada <= 1'b1;
         alarme_sem_rolha   <= 1'b0;
         vedadas            <= '0;
      end else begin
         estado             <= proximo;
         atuador_vedar      <= (proximo == VEDANDO);
         garrafa_liberada   <= (proximo == LIBERA);
         esteira_habilitada <= esteira_livre(proximo);
         alarme_sem_rolha   <= (proximo == SEM_ROLHA);
         if ((proximo == LIBERA) && (vedadas != '1)) begin
            vedadas <= vedadas + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_controle_vedacao.sv
// Bench for controle_vedacao: directed scenarios checked against a phase model
// every cycle, plus hand-computed pins on latency, pulse counts and saturation.
module tb_controle_vedacao;

   localparam int T    = 4;
   localparam int LARG = 8;
   localparam int MAXV = (1 << LARG) - 1;

   localparam int F_LIVRE = 0, F_PEDE = 1, F_SELA = 2, F_SOLTA = 3, F_SAIDA = 4, F_FALTA = 5;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            garrafa_presente = 1'b0;
   logic            modo_manual = 1'b0;
   logic            key_vedar = 1'b0;
   logic            rolha_disponivel = 1'b1;
   logic            disp_acionado = 1'b0;
   logic            dec;
   logic            atuador_vedar;
   logic            garrafa_liberada;
   logic            esteira_habilitada;
   logic            alarme_sem_rolha;
   logic [LARG-1:0] vedadas;

   int total = 0;
   int bad   = 0;
   bit ativo = 1'b0;
   int n_dec = 0;
   int n_atu = 0;
   int n_lib = 0;

   int m_fase = F_LIVRE;
   int m_rest = 0;
   int m_ved  = 0;

   controle_vedacao #(
      .TEMPO_VEDACAO   (T),
      .LARGURA_VEDADAS (LARG)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .garrafa_presente   (garrafa_presente),
      .modo_manual        (modo_manual),
      .key_vedar          (key_vedar),
      .rolha_disponivel   (rolha_disponivel),
      .disp_acionado      (disp_acionado),
      .dec                (dec),
      .atuador_vedar      (atuador_vedar),
      .garrafa_liberada   (garrafa_liberada),
      .esteira_habilitada (esteira_habilitada),
      .alarme_sem_rolha   (alarme_sem_rolha),
      .vedadas            (vedadas)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nome, input int atual, input int esperado);
      total = total + 1;
      if (atual != esperado) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d expected %0d at %0t", nome, atual, esperado, $time);
      end
   endtask

   // Phase model: what the station should be doing, advanced on each edge.
   always @(posedge clk) begin
      if (!reset) begin
         m_fase <= F_LIVRE;
         m_ved  <= 0;
      end else begin
         case (m_fase)
            F_LIVRE: if (garrafa_presente && (!modo_manual || key_vedar)) m_fase <= F_PEDE;
            F_PEDE: begin
               if (rolha_disponivel && !disp_acionado) begin
                  m_fase <= F_SELA;
                  m_rest <= T;
               end else if (!disp_acionado) begin
                  m_fase <= F_FALTA;
               end
            end
            F_SELA: begin
               m_rest <= m_rest - 1;
               if (m_rest == 1) begin
                  m_fase <= F_SOLTA;
                  m_ved  <= (m_ved == MAXV) ? MAXV : m_ved + 1;
               end
            end
            F_SOLTA: m_fase <= F_SAIDA;
            F_SAIDA: if (!garrafa_presente) m_fase <= F_LIVRE;
            F_FALTA: begin
               if (rolha_disponivel && !disp_acionado) m_fase <= F_PEDE;
               else if (!garrafa_presente)             m_fase <= F_LIVRE;
            end
            default: m_fase <= F_LIVRE;
         endcase
      end
   end

   always @(negedge clk) begin
      if (ativo) begin
         chk("dec", int'(dec), int'((m_fase == F_PEDE) && rolha_disponivel && !disp_acionado));
         chk("atuador_vedar", int'(atuador_vedar), int'(m_fase == F_SELA));
         chk("garrafa_liberada", int'(garrafa_liberada), int'(m_fase == F_SOLTA));
         chk("esteira_habilitada", int'(esteira_habilitada),
             int'((m_fase == F_LIVRE) || (m_fase == F_SOLTA) || (m_fase == F_SAIDA)));
         chk("alarme_sem_rolha", int'(alarme_sem_rolha), int'(m_fase == F_FALTA));
         chk("vedadas", int'(vedadas), m_ved);
         chk("dec_com_disp", int'(dec && disp_acionado), 0);
         n_dec <= n_dec + int'(dec);
         n_atu <= n_atu + int'(atuador_vedar);
         n_lib <= n_lib + int'(garrafa_liberada);
      end
   end

   task automatic passo();
      @(posedge clk);
      #1;
   endtask

   task automatic meio();
      @(negedge clk);
   endtask

   task automatic espera_liberacao();
      bit visto = 1'b0;
      for (int i = 0; i < 40 && !visto; i++) begin
         passo();
         meio();
         if (garrafa_liberada) visto = 1'b1;
      end
      chk("timeout_liberacao", int'(visto), 1);
   endtask

   // Seal one bottle in auto mode and let it leave; ends at posedge+1 in OCIOSO.
   task automatic ciclo_completo();
      garrafa_presente = 1'b1;
      espera_liberacao();
      passo();
      garrafa_presente = 1'b0;
      passo();
   endtask

   initial begin
      int d0, a0, l0;

      passo();
      passo();
      meio();
      chk("reset_esteira", int'(esteira_habilitada), 1);
      chk("reset_atuador", int'(atuador_vedar), 0);
      chk("reset_liberada", int'(garrafa_liberada), 0);
      chk("reset_alarme", int'(alarme_sem_rolha), 0);
      chk("reset_dec", int'(dec), 0);
      chk("reset_vedadas", int'(vedadas), 0);
      ativo = 1'b1;
      passo();
      reset = 1'b1;
      passo();

      // Normal auto cycle: dec 1 cycle after start, 4 actuator cycles, release next.
      d0 = n_dec; a0 = n_atu; l0 = n_lib;
      garrafa_presente = 1'b1;
      passo(); meio();
      chk("t1_dec", int'(dec), 1);
      chk("t1_esteira_parada", int'(esteira_habilitada), 0);
      for (int i = 0; i < T; i++) begin
         passo(); meio();
         chk("t1_atuador", int'(atuador_vedar), 1);
      end
      passo(); meio();
      chk("t1_liberada", int'(garrafa_liberada), 1);
      chk("t1_vedadas", int'(vedadas), 1);
      for (int i = 0; i < 6; i++) begin
         passo(); meio();
         chk("t1_sem_reselo", int'(dec), 0);
      end
      passo();
      chk("t1_num_dec", n_dec - d0, 1);
      chk("t1_num_atuador", n_atu - a0, T);
      chk("t1_num_liberada", n_lib - l0, 1);
      garrafa_presente = 1'b0;
      passo();

      // Refill stall: two REQUISITA cycles with disp_acionado, dec on the third.
      d0 = n_dec;
      garrafa_presente = 1'b1;
      disp_acionado = 1'b1;
      passo(); meio();
      chk("t2_dec_c1", int'(dec), 0);
      passo(); meio();
      chk("t2_dec_c2", int'(dec), 0);
      passo();
      disp_acionado = 1'b0;
      meio();
      chk("t2_dec_c3", int'(dec), 1);
      espera_liberacao();
      passo();
      garrafa_presente = 1'b0;
      passo();
      chk("t2_num_dec", n_dec - d0, 1);

      // No cork: alarm, then cork arrives and sealing resumes.
      d0 = n_dec;
      rolha_disponivel = 1'b0;
      garrafa_presente = 1'b1;
      passo(); passo();
      for (int i = 0; i < 3; i++) begin
         meio();
         chk("t3_alarme", int'(alarme_sem_rolha), 1);
         chk("t3_esteira", int'(esteira_habilitada), 0);
         passo();
      end
      rolha_disponivel = 1'b1;
      passo(); meio();
      chk("t3_alarme_cai", int'(alarme_sem_rolha), 0);
      chk("t3_dec", int'(dec), 1);
      espera_liberacao();
      passo();
      garrafa_presente = 1'b0;
      passo();
      chk("t3_num_dec", n_dec - d0, 1);

      // No cork, bottle removed by hand: back to OCIOSO with no dec.
      d0 = n_dec;
      rolha_disponivel = 1'b0;
      garrafa_presente = 1'b1;
      passo(); passo();
      garrafa_presente = 1'b0;
      passo(); meio();
      chk("t3b_alarme", int'(alarme_sem_rolha), 0);
      chk("t3b_esteira", int'(esteira_habilitada), 1);
      passo();
      rolha_disponivel = 1'b1;
      passo(); passo();
      chk("t3b_num_dec", n_dec - d0, 0);

      // Manual mode: bottle without key waits; key starts; key without bottle ignored.
      d0 = n_dec;
      modo_manual = 1'b1;
      garrafa_presente = 1'b1;
      for (int i = 0; i < 20; i++) passo();
      meio();
      chk("t4_espera_esteira", int'(esteira_habilitada), 1);
      passo();
      chk("t4_sem_dec", n_dec - d0, 0);
      key_vedar = 1'b1;
      passo();
      key_vedar = 1'b0;
      meio();
      chk("t4_dec", int'(dec), 1);
      espera_liberacao();
      passo();
      garrafa_presente = 1'b0;
      passo();
      d0 = n_dec;
      key_vedar = 1'b1;
      passo();
      key_vedar = 1'b0;
      for (int i = 0; i < 4; i++) passo();
      chk("t4_key_sem_garrafa", n_dec - d0, 0);
      modo_manual = 1'b0;

      // Reset in the third VEDANDO cycle aborts without a release.
      l0 = n_lib;
      garrafa_presente = 1'b1;
      passo(); passo(); passo(); passo();
      meio();
      chk("t5_vedando", int'(atuador_vedar), 1);
      reset = 1'b0;
      passo(); meio();
      chk("t5_atuador", int'(atuador_vedar), 0);
      chk("t5_vedadas", int'(vedadas), 0);
      chk("t5_esteira", int'(esteira_habilitada), 1);
      chk("t5_liberada", int'(garrafa_liberada), 0);
      passo();
      reset = 1'b1;
      garrafa_presente = 1'b0;
      for (int i = 0; i < 6; i++) passo();
      chk("t5_num_liberada", n_lib - l0, 0);

      // Saturation of the sealed-bottle counter.
      for (int i = 0; i < MAXV; i++) ciclo_completo();
      meio();
      chk("t6_vedadas_max", int'(vedadas), MAXV);
      passo();
      garrafa_presente = 1'b1;
      espera_liberacao();
      chk("t6_vedadas_sat", int'(vedadas), MAXV);
      passo();
      garrafa_presente = 1'b0;
      passo(); passo();

      ativo = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
